uart_cmd_ctrl: RTL and testbench

//   Command sequencer behind the UART receiver. Collects received bytes into
//   4-byte frames {SYNC, ADDR, DATA, CHK}, checks them, and issues one register

---
 rtl/uart_cmd_ctrl.sv | 170 +++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl - command sequencer behind the UART receiver.
// Collects {SYNC, ADDR, DATA, CHK} byte frames, validates the 8-bit additive
// checksum and issues one register write per good frame. Addresses 0xF0/0xF1
// load the receiver baud divider (low byte staged in a shadow, high byte commits).
//
// Ports
//   i_clk          system clock
//   i_rst_n        synchronous reset, active-low
//   i_rx_data      received byte, valid while i_rx_valid_n=0
//   i_rx_valid_n   active-low byte strobe, one cycle per byte
//   o_baud_div     divider for the UART receiver
//   o_wr_en        one-cycle register write strobe
//   o_wr_addr      write address (holds until the next write)
//   o_wr_data      write data (holds until the next write)
//   o_frame_ok     one-cycle pulse per accepted frame
//   o_err_cnt      saturating count of bad-checksum and timed-out frames
//   o_busy         high whenever a frame is in progress
//
// state | meaning
// ------+----------------------------------------------------------
// HUNT  | idle, waiting for SYNC_BYTE; other bytes dropped silently
// ADDR  | expecting the address byte
// DATA  | expecting the data byte
// CHK   | expecting the checksum byte (a SYNC here is still a checksum)
// EXEC  | one cycle while the registered frame actions are visible
module uart_cmd_ctrl #(
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int          TIMEOUT_CYC  = 100000,
  parameter logic [15:0] BAUD_DIV_RST = 16'd867
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid_n,
  output logic [15:0] o_baud_div,
  output logic        o_wr_en,
  output logic [7:0]  o_wr_addr,
  output logic [7:0]  o_wr_data,
  output logic        o_frame_ok,
  output logic [7:0]  o_err_cnt,
  output logic        o_busy
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {S_HUNT, S_ADDR, S_DATA, S_CHK, S_EXEC} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic [7:0]    shadow_q, shadow_d;
  logic [15:0]   baud_q, baud_d;
  logic          wr_en_q, wr_en_d;
  logic [7:0]    wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          frame_ok_q, frame_ok_d;
  logic [7:0]    err_cnt_q, err_cnt_d;

  logic byte_vld;
  logic in_frame;
  logic tmo_hit;
  logic chk_ok;
  logic err_inc;

  assign byte_vld = ~i_rx_valid_n;
  assign in_frame = (state_q == S_ADDR) || (state_q == S_DATA) || (state_q == S_CHK);
  // Timeout takes priority over a byte strobe on the same edge.
  assign tmo_hit  = in_frame && (tmo_cnt_q == TW'(TIMEOUT_CYC));
  assign chk_ok   = (i_rx_data == 8'(addr_q + data_q));

  // State register plus registered datapath/outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= S_HUNT;
      tmo_cnt_q  <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      shadow_q   <= '0;
      baud_q     <= BAUD_DIV_RST;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      frame_ok_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      tmo_cnt_q  <= tmo_cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      shadow_q   <= shadow_d;
      baud_q     <= baud_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      frame_ok_q <= frame_ok_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HUNT: if (byte_vld && (i_rx_data == SYNC_BYTE)) state_d = S_ADDR;
      S_ADDR: if (tmo_hit) state_d = S_HUNT; else if (byte_vld) state_d = S_DATA;
      S_DATA: if (tmo_hit) state_d = S_HUNT; else if (byte_vld) state_d = S_CHK;
      S_CHK: begin
        if (tmo_hit)       state_d = S_HUNT;
        else if (byte_vld) state_d = chk_ok ? S_EXEC : S_HUNT;
      end
      S_EXEC:  state_d = S_HUNT;
      default: state_d = S_HUNT;
    endcase
  end

  // Output / datapath next values. Frame actions are computed on the CHK
  // edge so the registered pulses line up with the EXEC cycle.
  always_comb begin
    addr_d     = addr_q;
    data_d     = data_q;
    shadow_d   = shadow_q;
    baud_d     = baud_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    frame_ok_d = 1'b0;
    err_inc    = 1'b0;

    if (!in_frame || byte_vld || tmo_hit) tmo_cnt_d = '0;
    else                                  tmo_cnt_d = tmo_cnt_q + 1'b1;

    if (tmo_hit) begin
      err_inc = 1'b1;
    end else if (byte_vld) begin
      case (state_q)
        S_ADDR: addr_d = i_rx_data;
        S_DATA: data_d = i_rx_data;
        S_CHK: begin
          if (chk_ok) begin
            frame_ok_d = 1'b1;
            if (addr_q < 8'hF0) begin
              wr_en_d   = 1'b1;
              wr_addr_d = addr_q;
              wr_data_d = data_q;
            end else if (addr_q == 8'hF0) begin
              shadow_d = data_q;
            end else if (addr_q == 8'hF1) begin
              baud_d = {data_q, shadow_q};
            end
          end else begin
            err_inc = 1'b1;
          end
        end
        default: ;
      endcase
    end

    err_cnt_d = (err_inc && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  assign o_baud_div = baud_q;
  assign o_wr_en    = wr_en_q;
  assign o_wr_addr  = wr_addr_q;
  assign o_wr_data  = wr_data_q;
  assign o_frame_ok = frame_ok_q;
  assign o_err_cnt  = err_cnt_q;
  assign o_busy     = (state_q != S_HUNT);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl - directed bench for uart_cmd_ctrl (TIMEOUT_CYC=50).
// Bytes are driven on the falling edge; outputs are sampled on falling edges.
module tb_uart_cmd_ctrl;

  localparam int TMO = 50;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [7:0]  i_rx_data = 8'h00;
  logic        i_rx_valid_n = 1'b1;
  logic [15:0] o_baud_div;
  logic        o_wr_en;
  logic [7:0]  o_wr_addr;
  logic [7:0]  o_wr_data;
  logic        o_frame_ok;
  logic [7:0]  o_err_cnt;
  logic        o_busy;

  int n_cmp = 0;
  int n_bad = 0;
  int wr_pulses = 0;
  int ok_pulses = 0;
  int wr0, ok0;
  int exp_err = 0;

  uart_cmd_ctrl #(
    .SYNC_BYTE    (8'hA5),
    .TIMEOUT_CYC  (TMO),
    .BAUD_DIV_RST (16'd867)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_rx_data    (i_rx_data),
    .i_rx_valid_n (i_rx_valid_n),
    .o_baud_div   (o_baud_div),
    .o_wr_en      (o_wr_en),
    .o_wr_addr    (o_wr_addr),
    .o_wr_data    (o_wr_data),
    .o_frame_ok   (o_frame_ok),
    .o_err_cnt    (o_err_cnt),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (o_wr_en)    wr_pulses++;
    if (o_frame_ok) ok_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Byte is accepted on the rising edge in the middle; returns on the
  // falling edge after it, where the registered frame outputs are visible.
  task automatic send_byte(input logic [7:0] b);
    @(negedge i_clk);
    i_rx_data    = b;
    i_rx_valid_n = 1'b0;
    @(negedge i_clk);
    i_rx_valid_n = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
    send_byte(8'hA5);
    send_byte(a);
    send_byte(d);
    send_byte(c);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  initial begin
    idle(2);
    // Reset values
    check("rst_baud",   o_baud_div, 16'd867);
    check("rst_wr_en",  o_wr_en, 0);
    check("rst_addr",   o_wr_addr, 0);
    check("rst_data",   o_wr_data, 0);
    check("rst_ok",     o_frame_ok, 0);
    check("rst_err",    o_err_cnt, 0);
    check("rst_busy",   o_busy, 0);
    i_rst_n = 1'b1;
    idle(1);

    // 1: good frame, outputs one cycle after CHK strobe
    send_frame(8'h10, 8'h22, 8'h32);
    check("t1_wr_en",  o_wr_en, 1);
    check("t1_addr",   o_wr_addr, 8'h10);
    check("t1_data",   o_wr_data, 8'h22);
    check("t1_ok",     o_frame_ok, 1);
    check("t1_err",    o_err_cnt, 0);
    idle(1);
    check("t1_wr_drop", o_wr_en, 0);
    check("t1_ok_drop", o_frame_ok, 0);
    check("t1_addr_hold", o_wr_addr, 8'h10);
    check("t1_busy",   o_busy, 0);

    // 2: bad checksum, then recovery
    wr0 = wr_pulses; ok0 = ok_pulses;
    send_frame(8'h10, 8'h22, 8'h33);
    exp_err++;
    idle(2);
    check("t2_err",    o_err_cnt, exp_err);
    check("t2_busy",   o_busy, 0);
    check("t2_nowr",   wr_pulses - wr0, 0);
    check("t2_nook",   ok_pulses - ok0, 0);
    send_frame(8'h20, 8'h30, 8'h50);
    check("t2_wr_en",  o_wr_en, 1);
    check("t2_addr",   o_wr_addr, 8'h20);
    check("t2_data",   o_wr_data, 8'h30);

    // 3: baud divider load via shadow
    idle(2);
    wr0 = wr_pulses; ok0 = ok_pulses;
    send_frame(8'hF0, 8'h5A, 8'h4A);
    idle(2);
    check("t3_baud_pre", o_baud_div, 16'd867);
    send_frame(8'hF1, 8'h01, 8'hF2);
    idle(2);
    check("t3_baud",   o_baud_div, 16'h015A);
    check("t3_ok",     ok_pulses - ok0, 2);
    check("t3_nowr",   wr_pulses - wr0, 0);

    // reserved address: frame accepted, nothing written, no error
    wr0 = wr_pulses; ok0 = ok_pulses;
    send_frame(8'hF5, 8'h00, 8'hF5);
    idle(2);
    check("rsv_ok",    ok_pulses - ok0, 1);
    check("rsv_nowr",  wr_pulses - wr0, 0);
    check("rsv_err",   o_err_cnt, exp_err);
    check("rsv_baud",  o_baud_div, 16'h015A);

    // 4: timeout mid-frame
    wr0 = wr_pulses;
    send_byte(8'hA5);
    send_byte(8'h10);
    idle(TMO - 5);
    check("t4_busy_pre", o_busy, 1);
    check("t4_err_pre",  o_err_cnt, exp_err);
    idle(15);
    exp_err++;
    check("t4_err",    o_err_cnt, exp_err);
    check("t4_busy",   o_busy, 0);
    send_byte(8'h22);
    send_byte(8'h32);
    idle(2);
    check("t4_nowr",   wr_pulses - wr0, 0);
    check("t4_err2",   o_err_cnt, exp_err);

    // 5: leading junk
    wr0 = wr_pulses;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_frame(8'h05, 8'h06, 8'h0B);
    idle(2);
    check("t5_wr",     wr_pulses - wr0, 1);
    check("t5_addr",   o_wr_addr, 8'h05);
    check("t5_data",   o_wr_data, 8'h06);
    check("t5_err",    o_err_cnt, exp_err);

    // SYNC in CHK slot is a (wrong) checksum, not a new frame
    wr0 = wr_pulses;
    send_frame(8'h10, 8'h22, 8'hA5);
    exp_err++;
    send_byte(8'h10);
    send_byte(8'h22);
    send_byte(8'h32);
    idle(2);
    check("sync_chk_err", o_err_cnt, exp_err);
    check("sync_chk_nowr", wr_pulses - wr0, 0);
    check("sync_chk_busy", o_busy, 0);

    // 6: saturation
    for (int i = 0; i < 300; i++) send_frame(8'h01, 8'h01, 8'h00);
    idle(2);
    check("t6_sat",    o_err_cnt, 8'hFF);
    send_frame(8'h01, 8'h01, 8'h00);
    idle(1);
    check("t6_sat_hold", o_err_cnt, 8'hFF);

    // reset mid-frame
    send_byte(8'hA5);
    send_byte(8'h10);
    check("t6_busy_mid", o_busy, 1);
    i_rst_n = 1'b0;
    idle(1);
    check("t6_rst_baud", o_baud_div, 16'd867);
    check("t6_rst_err",  o_err_cnt, 0);
    check("t6_rst_busy", o_busy, 0);
    check("t6_rst_addr", o_wr_addr, 0);
    check("t6_rst_data", o_wr_data, 0);
    check("t6_rst_wr",   o_wr_en, 0);
    check("t6_rst_ok",   o_frame_ok, 0);
    i_rst_n = 1'b1;
    idle(1);
    // stale bytes of the old frame must not resume it
    send_byte(8'h22);
    send_byte(8'h32);
    idle(1);
    check("t6_post_busy", o_busy, 0);
    check("t6_post_err",  o_err_cnt, 0);
    send_frame(8'h33, 8'h44, 8'h77);
    check("t6_post_wr",   o_wr_en, 1);
    check("t6_post_addr", o_wr_addr, 8'h33);
    check("t6_post_data", o_wr_data, 8'h44);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
